bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 27, width of the binary input operand.
REQ-002 Parameter DIGITS, default 8, number of BCD digits produced (one per 7-segment tube).
REQ-003 clk  input  1  system clock (100 MHz); all state SHALL change only on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 bin  input  BIN_W  unsigned binary operand; captured on the accepting edge.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 done  output  1  one-cycle pulse: bcd/ovf/blank are valid and updated.
REQ-009 bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0], held between conversions.
REQ-010 ovf  output  1  captured operand exceeded 10^DIGITS-1; held with bcd.
REQ-011 blank  output  DIGITS  per-digit leading-zero blank mask, bit i for digit i.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; transitions: IDLE->SHIFT on start=1, SHIFT->DONE after BIN_W shift cycles, DONE->IDLE unconditionally.
REQ-013 On the accepting edge the block SHALL capture bin into a shift register, clear the BCD scratch register and clear the iteration counter.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one (double-dabble).
REQ-015 done SHALL be high exactly in the cycle following the edge BIN_W+1 cycles after the accepting edge (28 cycles at default), for exactly one cycle.
REQ-016 bcd, ovf and blank SHALL update only on the edge entering DONE and SHALL hold their values otherwise.
REQ-017 If the captured operand > 10^DIGITS-1, bcd SHALL be all digits 9 and ovf=1; latency SHALL be unchanged.
REQ-018 start while busy=1 (SHIFT or DONE) SHALL be ignored; no queuing.
REQ-019 start=1 held continuously SHALL start a new conversion on the first IDLE cycle after each DONE (back-to-back period BIN_W+2 cycles).
REQ-020 The scratch register SHALL be 4*DIGITS bits; no intermediate carry beyond digit DIGITS-1 is retained.

Reset
REQ-021 With rst=1 at a clock edge, state SHALL become IDLE and busy=0, done=0, bcd=0, ovf=0, blank=0 on the following cycle.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; rst has priority over start.

Configuration
REQ-023 Macro BCD_LEAD_ZERO_BLANK_EN defined: blank bit i SHALL be 1 when digit i and all higher digits are 0, for i >= 1; bit 0 is always 0, so the value 0 shows a single "0".
REQ-024 Macro BCD_LEAD_ZERO_BLANK_EN undefined: blank SHALL be tied to all zeros and no blank logic SHALL be synthesised.

Structure
REQ-025 The shared package seg_pkg SHALL hold DIGITS/BIN_W defaults, the FSM state typedef and the BCD-digit typedef, for reuse by the tube-scan stage.
REQ-026 One sub-module bcd_add3 (combinational: 4-bit digit in, digit+3 if >= 5 out) SHALL be instantiated DIGITS times.
REQ-027 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-028 bin=0, start pulse -> done at cycle 28, bcd=0x00000000, ovf=0, blank=8'b11111110 (macro on).
REQ-029 bin=12345678 -> done at cycle 28, bcd=0x12345678, ovf=0; bin=1234 -> bcd=0x00001234, blank=8'b11110000 (macro on) / 8'b00000000 (macro off).
REQ-030 bin=99999999 -> bcd=0x99999999, ovf=0; bin=100000000 -> bcd=0x99999999, ovf=1, done still at cycle 28.
REQ-031 start pulsed at cycles 5 and 27 with different bin values -> only the first conversion is performed, exactly one done pulse, and bcd reflects the first value.
REQ-032 rst asserted at cycle 10 of a conversion -> no done pulse, all outputs 0 next cycle; a new start then completes normally in 28 cycles.
REQ-033 start held high for 100 cycles -> done pulses every 29 cycles, busy low for exactly one cycle between conversions.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the binary-to-BCD converter and the 7-segment tube
// scan stage that consumes its digits.
//   DIGITS_DEF / BIN_W_DEF : default digit count and operand width
//   state_t, ST_*          : converter FSM state type and encodings
//   bcd_digit_t            : one packed BCD digit
//   bcd_max_value()        : largest value representable in N decimal digits
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int DIGITS_DEF = 8;
   localparam int BIN_W_DEF  = 27;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

   typedef logic [3:0] bcd_digit_t;

   // 10^digits - 1, evaluated at elaboration time for the overflow limit.
   function automatic logic [63:0] bcd_max_value(input int digits);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction for a single BCD digit: a digit of
// 5 or more gets 3 added so that the following left shift carries correctly
// into the next decimal digit.
//   i_digit : BCD digit before correction
//   o_digit : corrected digit (i_digit + 3 when i_digit >= 5, else i_digit)
// -----------------------------------------------------------------------------
module bcd_add3
   import seg_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   bcd_digit_t w_sum;

   assign w_sum   = i_digit + 4'd3;
   assign o_digit = (i_digit >= 4'd5) ? w_sum : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) that
// feeds a DIGITS-tube 7-segment display. Operands above 10^DIGITS-1 saturate
// to all nines and raise ovf.
//
// Optional feature macro: BCD_LEAD_ZERO_BLANK_EN
//   defined   : blank[i] (i >= 1) is 1 when digit i and every higher digit are
//               zero; blank[0] is always 0 so a value of zero shows one "0".
//   undefined : blank is tied to zero and no blank logic exists.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, only honoured in IDLE
//   bin   : unsigned operand, captured on the accepting edge
//   busy  : high whenever the FSM is not in IDLE
//   done  : one-cycle pulse, bcd/ovf/blank freshly updated
//   bcd   : packed BCD result, digit 0 in bits [3:0], held between conversions
//   ovf   : captured operand exceeded 10^DIGITS-1, held with bcd
//   blank : per-digit leading-zero blank mask
//
// Timing: with the accepting edge counted as cycle 0, the FSM spends BIN_W
// cycles in SHIFT, one in DONE (done high) and returns to IDLE, so a held
// start gives a BIN_W+2 cycle conversion period.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
   import seg_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [DIGITS-1:0]     blank
);

   localparam int                SCR_W   = 4 * DIGITS;
   localparam int                CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
   localparam logic [63:0]       MAX_VAL  = bcd_max_value(DIGITS);

   // Control state
   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_done;

   // Datapath state
   logic [BIN_W-1:0]      r_op;
   logic [SCR_W-1:0]      r_scratch;
   logic                  r_ovf_pend;

   // Result registers
   logic [SCR_W-1:0]      r_bcd;
   logic                  r_ovf;

   // Combinational
   logic [SCR_W-1:0]      w_adj;
   logic [SCR_W-1:0]      w_scratch_next;
   logic                  w_unused_carry;
   logic [SCR_W-1:0]      w_result;
   logic                  w_accept;
   logic                  w_finish;

   // Per-digit add-3 correction ahead of the shift.
   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
         );
      end
   endgenerate

   // Shift {scratch, operand} left by one. The bit leaving the top digit is
   // discarded: for in-range operands it is always zero, and out-of-range
   // operands are replaced by all nines anyway.
   assign {w_unused_carry, w_scratch_next} = {w_adj, r_op[BIN_W-1]};

   assign w_result = r_ovf_pend ? {DIGITS{4'h9}} : w_scratch_next;

   assign w_accept = (r_state == ST_IDLE)  && start;
   assign w_finish = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

   // FSM and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_bcd   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_bcd   <= w_result;
                  r_ovf   <= r_ovf_pend;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand / scratch datapath; contents are don't-care outside SHIFT.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op       <= bin;
         r_scratch  <= '0;
         r_ovf_pend <= (64'(bin) > MAX_VAL);
      end else if (r_state == ST_SHIFT) begin
         r_op      <= r_op << 1;
         r_scratch <= w_scratch_next;
      end
   end

`ifdef BCD_LEAD_ZERO_BLANK_EN
   logic [DIGITS-1:0] r_blank;
   logic [DIGITS-1:0] w_blank_next;
   logic              w_zero_run;

   // Walk from the top digit down; a digit blanks while everything at and
   // above it is zero. Digit 0 never blanks.
   always_comb begin
      w_blank_next = '0;
      w_zero_run   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_run      = w_zero_run && (w_result[4*i +: 4] == 4'd0);
         w_blank_next[i] = w_zero_run;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blank <= '0;
      end else if (w_finish) begin
         r_blank <= w_blank_next;
      end
   end

   assign blank = r_blank;
`else
   assign blank = '0;
`endif

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq at default parameters. Expected
// results come from a decimal-arithmetic reference model (modulo/divide by
// ten, range compare for overflow and blanking).
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   localparam int     BIN_W  = 27;
   localparam int     DIGITS = 8;
   localparam longint LIM    = 99999999;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [BIN_W-1:0]     bin;
   logic                 busy;
   logic                 done;
   logic [4*DIGITS-1:0]  bcd;
   logic                 ovf;
   logic [DIGITS-1:0]    blank;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf),
      .blank (blank)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by repeated division; saturate above LIM;
   // blank[i] set when the displayed value is below 10^i.
   function automatic void model(input longint v, output logic [31:0] e_bcd,
                                 output logic e_ovf, output logic [7:0] e_blank);
      longint x;
      longint p;
      e_ovf = (v > LIM);
      x     = e_ovf ? LIM : v;
      e_bcd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         e_bcd[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      e_blank = '0;
`ifdef BCD_LEAD_ZERO_BLANK_EN
      x = e_ovf ? LIM : v;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         e_blank[i] = (x < p);
         p = p * 10;
      end
`else
      p = 0;
      if (p != 0) e_blank = '1;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete conversion from IDLE; checks latency, results, pulse width.
   task automatic run_conv(input logic [BIN_W-1:0] v);
      int          n;
      bit          seen;
      logic [31:0] eb;
      logic        eo;
      logic [7:0]  ebl;
      model(longint'(v), eb, eo, ebl);
      bin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = BIN_W'($urandom);
      chk("busy_after_accept", 64'(busy), 64'd1);
      n    = 0;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         tick();
         n++;
         if (done) seen = 1'b1;
      end
      chk("done_cycle", 64'(n + 1), 64'(BIN_W + 1));
      chk("bcd", 64'(bcd), 64'(eb));
      chk("ovf", 64'(ovf), 64'(eo));
      chk("blank", 64'(blank), 64'(ebl));
      tick();
      chk("done_width", 64'(done), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
      chk("bcd_hold", 64'(bcd), 64'(eb));
   endtask

   initial begin
      logic [BIN_W-1:0] v1;
      logic [BIN_W-1:0] v2;
      logic [BIN_W-1:0] hist [0:127];
      logic [31:0]      eb;
      logic             eo;
      logic [7:0]       ebl;
      int               ndone;
      int               last_done;
      int               idle_run;

      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bcd", 64'(bcd), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_blank", 64'(blank), 64'd0);
      tick();

      // Directed values, including the boundaries around 10^8-1.
      run_conv(BIN_W'(0));
      run_conv(BIN_W'(12345678));
      run_conv(BIN_W'(1234));
      run_conv(BIN_W'(99999999));
      run_conv(BIN_W'(100000000));
      run_conv(BIN_W'(134217727));
      run_conv(BIN_W'(9));
      run_conv(BIN_W'(10));

      // Randomized values across small, in-range and full-width operands.
      for (int k = 0; k < 18; k++) begin
         case (k % 3)
            0:       run_conv(BIN_W'($urandom_range(0, 9999)));
            1:       run_conv(BIN_W'($urandom_range(0, 99999999)));
            default: run_conv(BIN_W'($urandom));
         endcase
      end

      // Requests while busy (in SHIFT and in DONE) are dropped.
      v1 = BIN_W'($urandom_range(0, 99999999));
      v2 = BIN_W'($urandom_range(0, 99999999));
      if (v2 == v1) v2 = v1 ^ BIN_W'(1);
      model(longint'(v1), eb, eo, ebl);
      bin   = v1;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (done) ndone++;
         start = (c == 22 || c == 27);
         if (start) bin = v2;
      end
      start = 1'b0;
      chk("ignore_single_done", 64'(ndone), 64'd1);
      chk("ignore_first_value", 64'(bcd), 64'(eb));
      chk("ignore_idle", 64'(busy), 64'd0);

      // Reset in the middle of a conversion, with start asserted alongside.
      run_conv(BIN_W'(87654321));
      bin   = BIN_W'(55555);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_bcd", 64'(bcd), 64'd0);
      chk("abort_ovf", 64'(ovf), 64'd0);
      chk("abort_blank", 64'(blank), 64'd0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      run_conv(BIN_W'(4321));

      // start held high: back-to-back conversions.
      start     = 1'b1;
      ndone     = 0;
      last_done = -1;
      idle_run  = 0;
      for (int c = 0; c < 100; c++) begin
         bin     = BIN_W'($urandom);
         hist[c] = bin;
         tick();
         if (done) begin
            ndone++;
            if (last_done >= 0) chk("held_period", 64'(c + 1 - last_done), 64'd29);
            last_done = c + 1;
            if (c >= 27) begin
               model(longint'(hist[c - 27]), eb, eo, ebl);
               chk("held_bcd", 64'(bcd), 64'(eb));
               chk("held_ovf", 64'(ovf), 64'(eo));
            end
         end
         if (!busy) begin
            idle_run++;
         end else begin
            if (idle_run > 0) chk("held_idle_len", 64'(idle_run), 64'd1);
            idle_run = 0;
         end
      end
      start = 1'b0;
      chk("held_count", 64'(ndone), 64'd3);
      repeat (32) tick();
      chk("held_end_idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
